cfg_ro_image_loader: RTL and testbench

Parametrised successor to the static config tie-off block. Drives the read-only configuration fields of func0 and func1 for `NUM_AFU` AFUs. Fields start at parameter defaults; after reset (or on request) the block fetches a card image from an external word source, validates it, and commits it atomically. It sits between the card image source (flash/VPD controller) and the cfg_func0/cfg_func1 register files.

---
 rtl/cfg_ro_pkg.sv | 33 +++
 rtl/cfg_ro_img_fetch.sv | 56 +++++
 rtl/cfg_ro_image_loader.sv | 206 ++++++++++++++++++++
 tb/tb_cfg_ro_image_loader.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_ro_pkg.sv
// cfg_ro_pkg: shared constants for the read-only
// config image loader (magic, word offsets, status, states).
package cfg_ro_pkg;

  localparam logic [15:0] IMG_MAGIC = 16'h4F43;

  localparam logic [7:0] W0 = 8'd0;
  localparam logic [7:0] W1 = 8'd1;
  localparam logic [7:0] W2 = 8'd2;
  localparam logic [7:0] W3 = 8'd3;
  localparam logic [7:0] W4 = 8'd4;
  localparam logic [7:0] W5 = 8'd5;
  localparam logic [7:0] W6 = 8'd6;
  localparam logic [7:0] W7 = 8'd7;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_MAGIC   = 3'd1;
  localparam logic [2:0] ST_AFU_CNT = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;
  localparam logic [2:0] ST_IMG_ERR = 3'd5;
  localparam logic [2:0] ST_BAR     = 3'd6;
  localparam logic [2:0] ST_BUSY    = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_CHECK  = 3'd1,
    S_COMMIT = 3'd2,
    S_DONE   = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

endpackage

// File: rtl/cfg_ro_img_fetch.sv
// cfg_ro_img_fetch: walks the image word by word,
// owns the request/address and the per-word timeout.
module cfg_ro_img_fetch
  import cfg_ro_pkg::*;
#(
  parameter int NW      = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic       abort,
  input  logic       img_valid,
  input  logic       img_err,
  output logic       img_req,
  output logic [7:0] img_addr,
  output logic       acc,
  output logic       err_stb,
  output logic       tmo_stb,
  output logic       last
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  ADDR_END = 8'(NW - 1);

  logic [15:0] cnt;

  assign err_stb = img_req && img_err;
  assign acc     = img_req && img_valid && !img_err;
  assign tmo_stb = img_req && !img_valid && !img_err
                && (cnt == TMO_LAST);
  assign last    = acc && (img_addr == ADDR_END);

  // request/address sequencing and per-word stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_req  <= 1'b0;
      img_addr <= '0;
      cnt      <= '0;
    end else if (!active || abort || err_stb
                 || tmo_stb || last) begin
      img_req  <= 1'b0;
      img_addr <= '0;
      cnt      <= '0;
    end else begin
      img_req <= 1'b1;
      if (acc) begin
        img_addr <= img_addr + 8'd1;
        cnt      <= '0;
      end else if (img_req) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/cfg_ro_image_loader.sv
// cfg_ro_image_loader: fetches, validates and atomically
// commits the card image onto the func0/func1 RO fields.
module cfg_ro_image_loader
  import cfg_ro_pkg::*;
#(
  parameter int          NUM_AFU         = 1,
  parameter int          TIMEOUT         = 1024,
  parameter logic [15:0] DFLT_SUBSYS_ID  = 16'h060F,
  parameter logic [15:0] DFLT_SUBSYS_VID = 16'h1014,
  parameter logic [63:0] DFLT_DSN        = 64'hDEAD_DEAD_DEAD_DEAD,
  parameter logic [63:0] DFLT_BAR0_SIZE  = 64'hFFFF_FFFF_FC00_0000,
  parameter logic [4:0]  DFLT_PASID_W    = 5'b01001,
  parameter logic [11:0] DFLT_ACTAG_LEN  = 12'h020
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic                    img_req,
  output logic [7:0]              img_addr,
  input  logic                    img_valid,
  input  logic [31:0]             img_data,
  input  logic                    img_err,
  input  logic                    reload,
  output logic [15:0]             f0_ro_csh_subsystem_id,
  output logic [15:0]             f0_ro_csh_subsystem_vendor_id,
  output logic [63:0]             f0_ro_dsn_serial_number,
  output logic [15:0]             f1_ro_csh_subsystem_id,
  output logic [15:0]             f1_ro_csh_subsystem_vendor_id,
  output logic [63:0]             f1_ro_csh_mmio_bar0_size,
  output logic [4:0]              f1_ro_pasid_max_pasid_width,
  output logic [4:0]              f1_ro_ofunc_max_afu_index,
  output logic [5*NUM_AFU-1:0]    f1_ro_octrl_pasid_len_supported,
  output logic [12*NUM_AFU-1:0]   f1_ro_octrl_actag_len_supported,
  output logic                    cfg_ro_valid,
  output logic                    cfg_ro_src,
  output logic [2:0]              cfg_ro_status
);

  localparam int NW = 8 + NUM_AFU;

  state_e state;

  logic acc;
  logic err_stb;
  logic tmo_stb;
  logic last;
  logic abort;
  logic w0_bad_magic;
  logic w0_bad_cnt;
  logic fetch_fail;
  logic chk_fail;
  logic [2:0] fail_code;
  logic [2:0] chk_code;

  logic [31:0]           csum;
  logic [15:0]           sh_sid;
  logic [15:0]           sh_vid;
  logic [63:0]           sh_dsn;
  logic [63:0]           sh_bar;
  logic [4:0]            sh_pw;
  logic [5*NUM_AFU-1:0]  sh_pl;
  logic [12*NUM_AFU-1:0] sh_al;

  assign w0_bad_magic = img_data[31:16] != IMG_MAGIC;
  assign w0_bad_cnt   = img_data[7:0] != 8'(NUM_AFU);
  assign abort = acc && (img_addr == W0)
              && (w0_bad_magic || w0_bad_cnt);

  cfg_ro_img_fetch #(
    .NW      (NW),
    .TIMEOUT (TIMEOUT)
  ) u_fetch (
    .clk       (clock),
    .rst_n     (reset_n),
    .active    (state == S_FETCH),
    .abort     (abort),
    .img_valid (img_valid),
    .img_err   (img_err),
    .img_req   (img_req),
    .img_addr  (img_addr),
    .acc       (acc),
    .err_stb   (err_stb),
    .tmo_stb   (tmo_stb),
    .last      (last)
  );

  assign fetch_fail = err_stb || tmo_stb || abort;

  // failure code while fetching; error beats valid
  always_comb begin
    fail_code = ST_BUSY;
    unique case (1'b1)
      err_stb: fail_code = ST_IMG_ERR;
      tmo_stb: fail_code = ST_TIMEOUT;
      abort:   fail_code = w0_bad_magic ? ST_MAGIC
                                        : ST_AFU_CNT;
      default: fail_code = ST_BUSY;
    endcase
  end

  assign chk_fail = (csum != 32'd0)
                 || (sh_bar[19:0] != 20'd0);
  assign chk_code = (csum != 32'd0) ? ST_CSUM : ST_BAR;

  // stage accepted words into the shadow image
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_sid <= '0;
      sh_vid <= '0;
      sh_dsn <= '0;
      sh_bar <= '0;
      sh_pw  <= '0;
      sh_pl  <= '0;
      sh_al  <= '0;
    end else if (acc) begin
      if (img_addr == W1) begin
        sh_sid <= img_data[31:16];
        sh_vid <= img_data[15:0];
      end
      if (img_addr == W2) sh_dsn[31:0]  <= img_data;
      if (img_addr == W3) sh_dsn[63:32] <= img_data;
      if (img_addr == W4) sh_bar[31:0]  <= img_data;
      if (img_addr == W5) sh_bar[63:32] <= img_data;
      if (img_addr == W6) sh_pw <= img_data[4:0];
      for (int n = 0; n < NUM_AFU; n++) begin
        if (img_addr == W7 + 8'(n)) begin
          sh_pl[5*n +: 5]   <= img_data[16:12];
          sh_al[12*n +: 12] <= img_data[11:0];
        end
      end
    end
  end

  // running image sum, cleared before each new fetch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum <= '0;
    end else if (state == S_DONE || state == S_FAIL) begin
      csum <= '0;
    end else if (acc) begin
      csum <= csum + img_data;
    end
  end

  // load sequencer and committed output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_FETCH;
      cfg_ro_valid  <= 1'b0;
      cfg_ro_src    <= 1'b0;
      cfg_ro_status <= ST_BUSY;
      f0_ro_csh_subsystem_id          <= DFLT_SUBSYS_ID;
      f0_ro_csh_subsystem_vendor_id   <= DFLT_SUBSYS_VID;
      f0_ro_dsn_serial_number         <= DFLT_DSN;
      f1_ro_csh_mmio_bar0_size        <= DFLT_BAR0_SIZE;
      f1_ro_pasid_max_pasid_width     <= DFLT_PASID_W;
      f1_ro_octrl_pasid_len_supported <= {NUM_AFU{DFLT_PASID_W}};
      f1_ro_octrl_actag_len_supported <= {NUM_AFU{DFLT_ACTAG_LEN}};
    end else begin
      unique case (state)
        S_FETCH: begin
          if (fetch_fail) begin
            state         <= S_FAIL;
            cfg_ro_valid  <= 1'b1;
            cfg_ro_status <= fail_code;
          end else if (last) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (chk_fail) begin
            state         <= S_FAIL;
            cfg_ro_valid  <= 1'b1;
            cfg_ro_status <= chk_code;
          end else begin
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          state         <= S_DONE;
          cfg_ro_valid  <= 1'b1;
          cfg_ro_src    <= 1'b1;
          cfg_ro_status <= ST_OK;
          f0_ro_csh_subsystem_id          <= sh_sid;
          f0_ro_csh_subsystem_vendor_id   <= sh_vid;
          f0_ro_dsn_serial_number         <= sh_dsn;
          f1_ro_csh_mmio_bar0_size        <= sh_bar;
          f1_ro_pasid_max_pasid_width     <= sh_pw;
          f1_ro_octrl_pasid_len_supported <= sh_pl;
          f1_ro_octrl_actag_len_supported <= sh_al;
        end
        S_DONE, S_FAIL: begin
          if (reload) begin
            state        <= S_FETCH;
            cfg_ro_valid <= 1'b0;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign f1_ro_csh_subsystem_id        = f0_ro_csh_subsystem_id;
  assign f1_ro_csh_subsystem_vendor_id = f0_ro_csh_subsystem_vendor_id;
  assign f1_ro_ofunc_max_afu_index     = 5'(NUM_AFU - 1);

endmodule

// File: tb/tb_cfg_ro_image_loader.sv
// tb_cfg_ro_image_loader: random and directed image loads
// against a queue-based reference model of the loader.
module tb_cfg_ro_image_loader;

  localparam int NA  = 2;
  localparam int NW  = 8 + NA;
  localparam int TMO = 16;

  typedef struct packed {
    logic [15:0] sid;
    logic [15:0] vid;
    logic [63:0] dsn;
    logic [63:0] bar;
    logic [4:0]  pw;
    logic [9:0]  pl;
    logic [23:0] al;
  } flds_t;

  typedef struct packed {
    flds_t      f;
    logic       src;
    logic [2:0] st;
    int         lat;
  } exp_t;

  localparam flds_t DFLT = {16'h060F, 16'h1014,
    64'hDEAD_DEAD_DEAD_DEAD, 64'hFFFF_FFFF_FC00_0000,
    5'b01001, 10'b01001_01001, 24'h020_020};

  logic         clock = 1'b0;
  logic         reset_n;
  logic         img_req;
  logic [7:0]   img_addr;
  logic         img_valid;
  logic [31:0]  img_data;
  logic         img_err;
  logic         reload;
  logic [15:0]  f0_sid, f0_vid, f1_sid, f1_vid;
  logic [63:0]  f0_dsn, f1_bar;
  logic [4:0]   f1_pw, f1_maxafu;
  logic [9:0]   f1_pl;
  logic [23:0]  f1_al;
  logic         cfg_ro_valid, cfg_ro_src;
  logic [2:0]   cfg_ro_status;

  cfg_ro_image_loader #(
    .NUM_AFU (NA),
    .TIMEOUT (TMO)
  ) dut (
    .clock                           (clock),
    .reset_n                         (reset_n),
    .img_req                         (img_req),
    .img_addr                        (img_addr),
    .img_valid                       (img_valid),
    .img_data                        (img_data),
    .img_err                         (img_err),
    .reload                          (reload),
    .f0_ro_csh_subsystem_id          (f0_sid),
    .f0_ro_csh_subsystem_vendor_id   (f0_vid),
    .f0_ro_dsn_serial_number         (f0_dsn),
    .f1_ro_csh_subsystem_id          (f1_sid),
    .f1_ro_csh_subsystem_vendor_id   (f1_vid),
    .f1_ro_csh_mmio_bar0_size        (f1_bar),
    .f1_ro_pasid_max_pasid_width     (f1_pw),
    .f1_ro_ofunc_max_afu_index       (f1_maxafu),
    .f1_ro_octrl_pasid_len_supported (f1_pl),
    .f1_ro_octrl_actag_len_supported (f1_al),
    .cfg_ro_valid                    (cfg_ro_valid),
    .cfg_ro_src                      (cfg_ro_src),
    .cfg_ro_status                   (cfg_ro_status)
  );

  always #5 clock = ~clock;

  flds_t out_f;
  assign out_f = {f0_sid, f0_vid, f0_dsn, f1_bar,
                  f1_pw, f1_pl, f1_al};

  int errors = 0;
  int checks = 0;

  logic [31:0] img [NW];
  int   err_at   = -1;
  int   stall_at = -1;
  int   wait_max = 0;
  exp_t q[$];
  flds_t mdl     = DFLT;
  logic  mdl_src = 1'b0;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void fix_csum();
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < NW - 1; i++) s = s + img[i];
    img[NW-1] = 32'd0 - s;
  endfunction

  function automatic void mk_img(input flds_t f);
    img[0] = {16'h4F43, 8'($urandom), 8'(NA)};
    img[1] = {f.sid, f.vid};
    img[2] = f.dsn[31:0];
    img[3] = f.dsn[63:32];
    img[4] = f.bar[31:0];
    img[5] = f.bar[63:32];
    img[6] = {27'd0, f.pw};
    for (int n = 0; n < NA; n++)
      img[7+n] = {15'd0, f.pl[5*n +: 5], f.al[12*n +: 12]};
    fix_csum();
  endfunction

  function automatic flds_t rnd_f();
    flds_t f;
    f.sid = 16'($urandom);
    f.vid = 16'($urandom);
    f.dsn = {32'($urandom), 32'($urandom)};
    f.bar = {32'($urandom), 32'($urandom)} & ~64'hF_FFFF;
    f.pw  = 5'($urandom);
    f.pl  = 10'($urandom);
    f.al  = 24'($urandom);
    return f;
  endfunction

  // what the loader must report for the current image/source
  function automatic exp_t predict(input flds_t prev,
                                   input logic psrc);
    exp_t e;
    logic [31:0] sum;
    int st;
    int lat;
    e.f = prev;
    e.src = psrc;
    st = -1;
    lat = -1;
    sum = 32'd0;
    for (int i = 0; i < NW && st < 0; i++) begin
      if (err_at == i) begin
        st = 5; lat = i + 1;
      end else if (stall_at == i) begin
        st = 4; lat = i + TMO;
      end else begin
        sum = sum + img[i];
        if (i == 0 && img[0][31:16] != 16'h4F43) begin
          st = 1; lat = 1;
        end else if (i == 0 && img[0][7:0] != 8'(NA)) begin
          st = 2; lat = 1;
        end
      end
    end
    if (st < 0) begin
      if (sum != 32'd0) begin
        st = 3; lat = NW + 1;
      end else if (img[4][19:0] != 20'd0) begin
        st = 6; lat = NW + 1;
      end else begin
        st = 0; lat = NW + 2;
        e.src = 1'b1;
        e.f.sid = img[1][31:16];
        e.f.vid = img[1][15:0];
        e.f.dsn = {img[3], img[2]};
        e.f.bar = {img[5], img[4]};
        e.f.pw  = img[6][4:0];
        for (int n = 0; n < NA; n++) begin
          e.f.pl[5*n +: 5]   = img[7+n][16:12];
          e.f.al[12*n +: 12] = img[7+n][11:0];
        end
      end
    end
    e.st  = 3'(st);
    e.lat = (wait_max == 0) ? lat : -1;
    return e;
  endfunction

  task automatic push();
    exp_t e;
    e = predict(mdl, mdl_src);
    q.push_back(e);
    mdl = e.f;
    mdl_src = e.src;
  endtask

  task automatic pulse_reload();
    @(negedge clock);
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
  endtask

  task automatic wait_done(input bit noisy);
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (q.size() == 0) break;
      reload = noisy && ($urandom_range(0, 4) == 0);
    end
    reload = 1'b0;
    chk("load_done", 256'(q.size()), 256'(0));
    q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 256'(cfg_ro_valid), 256'(0));
    chk({tag, "_src"}, 256'(cfg_ro_src), 256'(0));
    chk({tag, "_status"}, 256'(cfg_ro_status), 256'(7));
    chk({tag, "_req"}, 256'(img_req), 256'(0));
    chk({tag, "_addr"}, 256'(img_addr), 256'(0));
    chk({tag, "_fields"}, 256'(out_f), 256'(DFLT));
    chk({tag, "_f1_sid"}, 256'(f1_sid), 256'(DFLT.sid));
    chk({tag, "_maxafu"}, 256'(f1_maxafu), 256'(NA - 1));
  endtask

  // word source: random wait states, injected error/stall,
  // random junk on the bus while no request is pending
  int cur = -1;
  int wcnt = 0;
  bit src_on = 1'b0;
  always @(negedge clock) begin
    img_data = $urandom;
    if (!reset_n || !img_req) begin
      src_on = 1'b0;
      img_valid = 1'($urandom);
      img_err   = 1'($urandom);
    end else begin
      if (!src_on || cur != int'(img_addr)) begin
        src_on = 1'b1;
        cur = int'(img_addr);
        wcnt = int'($urandom_range(0, wait_max));
      end
      img_valid = 1'b0;
      img_err   = 1'b0;
      if (cur < NW && stall_at != cur) begin
        if (wcnt > 0) begin
          wcnt--;
        end else if (err_at == cur) begin
          img_err   = 1'b1;
          img_valid = 1'($urandom);
        end else begin
          img_valid = 1'b1;
          img_data  = img[cur];
        end
      end
    end
  end

  // monitor: pops one expectation per completed load
  int    cyc = 0;
  int    t0 = 0;
  bit    started = 1'b0;
  bit    hold_bad = 1'b0;
  bit    pv = 1'b0;
  flds_t held = DFLT;
  logic  held_src = 1'b0;
  exp_t  em;
  always @(posedge clock) begin
    #1;
    cyc++;
    if (!reset_n) begin
      held = DFLT;
      held_src = 1'b0;
      started = 1'b0;
      hold_bad = 1'b0;
      pv = 1'b0;
    end else begin
      if (!cfg_ro_valid) begin
        if (out_f !== held || cfg_ro_src !== held_src)
          hold_bad = 1'b1;
        if (img_req && !started) begin
          started = 1'b1;
          t0 = cyc;
        end
      end else if (!pv) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 256'(q.size()), 256'(1));
        end else begin
          em = q.pop_front();
          chk("status", 256'(cfg_ro_status), 256'(em.st));
          chk("src", 256'(cfg_ro_src), 256'(em.src));
          chk("fields", 256'(out_f), 256'(em.f));
          chk("f1_vid", 256'(f1_vid), 256'(em.f.vid));
          chk("req_low", 256'(img_req), 256'(0));
          chk("hold", 256'(hold_bad), 256'(0));
          if (em.lat >= 0)
            chk("latency", 256'(cyc - t0), 256'(em.lat));
          held = em.f;
          held_src = em.src;
        end
        started = 1'b0;
        hold_bad = 1'b0;
      end
      pv = cfg_ro_valid;
    end
  end

  flds_t fa;
  flds_t fb;

  initial begin
    reset_n = 1'b0;
    reload = 1'b0;
    img_valid = 1'b0;
    img_err = 1'b0;
    img_data = 32'd0;
    repeat (3) @(negedge clock);
    chk_reset("reset");

    // bad magic straight after reset
    mk_img(rnd_f());
    img[0] = 32'h4F41_0001;
    push();
    reset_n = 1'b1;
    wait_done(1'b0);
    chk("magic_dflt", 256'(out_f), 256'(DFLT));

    // checksum off by one
    mk_img(rnd_f());
    img[NW-1] = img[NW-1] + 32'd1;
    push();
    pulse_reload();
    wait_done(1'b0);
    chk("csum_src", 256'(cfg_ro_src), 256'(0));
    chk("csum_dsn", 256'(f0_dsn), 256'(64'hDEAD_DEAD_DEAD_DEAD));

    // good image
    fa.sid = 16'h0667;
    fa.vid = 16'h1014;
    fa.dsn = 64'h0123_4567_89AB_CDEF;
    fa.bar = 64'hFFFF_FFFF_FFF0_0000;
    fa.pw  = 5'd20;
    fa.pl  = {5'd7, 5'd3};
    fa.al  = {12'h040, 12'h011};
    mk_img(fa);
    push();
    pulse_reload();
    wait_done(1'b0);
    chk("good_sid", 256'(f0_sid), 256'(16'h0667));
    chk("good_actag1", 256'(f1_al[23:12]), 256'(12'h040));
    chk("good_status", 256'(cfg_ro_status), 256'(0));

    // source stalls at word 4
    mk_img(rnd_f());
    stall_at = 4;
    push();
    pulse_reload();
    wait_done(1'b0);
    stall_at = -1;

    // reload with a modified image, noisy reloads
    fb = fa;
    fb.sid = 16'h0B0B;
    fb.al  = {12'h0FF, 12'h001};
    mk_img(fb);
    push();
    pulse_reload();
    wait_done(1'b1);

    // random images and faults
    for (int k = 0; k < 14; k++) begin
      int md;
      mk_img(rnd_f());
      wait_max = int'($urandom_range(0, 3));
      md = int'($urandom_range(0, 8));
      err_at = -1;
      stall_at = -1;
      case (md)
        3: begin
          img[0][31:16] = 16'h4F43
                        ^ 16'($urandom_range(1, 65535));
          fix_csum();
        end
        4: begin
          img[0][7:0] = 8'($urandom_range(3, 255));
          fix_csum();
        end
        5: img[NW-1] = img[NW-1]
                     + 32'($urandom_range(1, 1000));
        6: begin
          img[4][19:0] = 20'($urandom_range(1, 20'hF_FFFF));
          fix_csum();
        end
        7: err_at = int'($urandom_range(0, NW - 1));
        8: stall_at = int'($urandom_range(0, NW - 1));
        default: ;
      endcase
      push();
      pulse_reload();
      wait_done(1'($urandom));
    end
    err_at = -1;
    stall_at = -1;
    wait_max = 0;

    // reset in the middle of a fetch
    mk_img(rnd_f());
    pulse_reload();
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (img_req && img_addr == 8'd5) break;
    end
    chk("mid_addr", 256'(img_addr), 256'(5));
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    mdl = DFLT;
    mdl_src = 1'b0;
    mk_img(rnd_f());
    push();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (img_req) break;
    end
    chk("restart_addr", 256'(img_addr), 256'(0));
    wait_done(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
